// File: rtl/timing_nco_loop_pkg.sv
// Shared types and constants for the MSK symbol-timing loop.
// tau is an unsigned Q5.27 sample offset; loop arithmetic uses 34-bit signed values.
package msk_timing_pkg;

  localparam int FRAC_W = 27;
  localparam int PH_W   = 5;
  localparam int ACC_W  = 34;

  typedef logic [31:0]             tau_t;
  typedef logic signed [ACC_W-1:0] acc_t;

  typedef enum logic [1:0] {
    SLIP_NONE = 2'b00,
    SLIP_OVF  = 2'b01,
    SLIP_UDF  = 2'b10
  } slip_e;

  // Modulus of tau: OSF samples expressed in Q5.27.
  function automatic acc_t tau_mod(input int osf);
    return acc_t'(osf) <<< FRAC_W;
  endfunction

endpackage

// File: rtl/timing_nco_loop_if.sv
// Sample/error inputs and re-timed outputs of the timing controller.
// The master drives the raw stream and TED errors; the slave is the controller.
interface timing_nco_loop_if
  import msk_timing_pkg::*;
#(
  parameter int WIQ = 16,
  parameter int WE  = 18
);

  logic [WIQ-1:0]       i_raw_i;
  logic [WIQ-1:0]       q_raw_i;
  logic                 iq_raw_val_i;
  logic signed [WE-1:0] ted_err_i;
  logic                 ted_val_i;

  logic [WIQ-1:0]       i_raw_o;
  logic [WIQ-1:0]       q_raw_o;
  logic                 iq_raw_val_o;
  logic                 sym_valid_o;
  logic [PH_W-1:0]      phase_int_o;
  logic [FRAC_W-1:0]    mu_o;
  logic [1:0]           slip_o;
  logic [31:0]          integ_o;

  modport master (
    output i_raw_i, q_raw_i, iq_raw_val_i, ted_err_i, ted_val_i,
    input  i_raw_o, q_raw_o, iq_raw_val_o, sym_valid_o, phase_int_o, mu_o, slip_o, integ_o
  );

  modport slave (
    input  i_raw_i, q_raw_i, iq_raw_val_i, ted_err_i, ted_val_i,
    output i_raw_o, q_raw_o, iq_raw_val_o, sym_valid_o, phase_int_o, mu_o, slip_o, integ_o
  );

endinterface

// File: rtl/timing_nco_loop_filter.sv
// PI loop filter: registers the TED error, then produces a clamped tau step
// and updates the saturating integrator one cycle later.
module timing_loop_filter
  import msk_timing_pkg::*;
#(
  parameter int     WE       = 18,
  parameter int     KP_SHIFT = 2,
  parameter int     KI_SHIFT = 8,
  parameter longint INT_LIM  = 64'sd67108864
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [WE-1:0] err_i,
  input  logic                 err_val_i,
  output acc_t                 delta_o,
  output logic                 delta_val_o,
  output logic signed [31:0]   integ_o
);

  localparam acc_t LIM      = acc_t'(INT_LIM);
  localparam acc_t STEP_MAX = acc_t'(1) <<< FRAC_W;
  localparam int   ES_SHIFT = FRAC_W - (WE - 1);

  logic signed [WE-1:0] err_q;
  logic                 err_val_q;
  logic signed [31:0]   integ_q, integ_d;

  acc_t e_s, integ_sum, integ_sat, delta_raw;

  // NOTE: every variable written here gets a value on every path, so no latch is inferred.
  always_comb begin
    e_s       = acc_t'(err_q) <<< ES_SHIFT;
    integ_sum = acc_t'(integ_q) + (e_s >>> KI_SHIFT);

    if (integ_sum > LIM)       integ_sat = LIM;
    else if (integ_sum < -LIM) integ_sat = -LIM;
    else                       integ_sat = integ_sum;

    delta_raw = (e_s >>> KP_SHIFT) + integ_sat;

    if (delta_raw > STEP_MAX)       delta_o = STEP_MAX;
    else if (delta_raw < -STEP_MAX) delta_o = -STEP_MAX;
    else                            delta_o = delta_raw;

    integ_d = err_val_q ? integ_sat[31:0] : integ_q;
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q     <= '0;
      err_val_q <= 1'b0;
      integ_q   <= '0;
    end else begin
      err_q     <= err_i;
      err_val_q <= err_val_i;
      integ_q   <= integ_d;
    end
  end

  assign delta_val_o = err_val_q;
  assign integ_o     = integ_q;

endmodule

// File: rtl/timing_nco_loop.sv
// Symbol-timing controller: re-times the raw I/Q stream, counts samples into
// symbol strobes and maintains tau (phase_int/mu) under PI loop control.
module timing_nco_loop
  import msk_timing_pkg::*;
#(
  parameter int     OSF      = 20,
  parameter int     WIQ      = 16,
  parameter int     WE       = 18,
  parameter int     KP_SHIFT = 2,
  parameter int     KI_SHIFT = 8,
  parameter longint INT_LIM  = 64'sd67108864,
  parameter tau_t   TAU_INIT = 32'd1342177280   // 10.0 samples
) (
  input logic              clk,
  input logic              rst,
  timing_nco_loop_if.slave bus
);

  localparam acc_t            TAU_MOD  = tau_mod(OSF);
  localparam logic [PH_W-1:0] CNT_LAST = PH_W'(OSF - 1);

  logic [PH_W-1:0]   cnt_q, cnt_d;
  tau_t              tau_q, tau_d;
  slip_e             slip_q, slip_d;
  logic [WIQ-1:0]    i_q, q_q;
  logic              val_q, sym_q;
  logic [PH_W-1:0]   phase_q;
  logic [FRAC_W-1:0] mu_q;

  acc_t               delta, tau_sum;
  logic               delta_val;
  logic signed [31:0] integ;
  logic               strobe;

  timing_loop_filter #(
    .WE       (WE),
    .KP_SHIFT (KP_SHIFT),
    .KI_SHIFT (KI_SHIFT),
    .INT_LIM  (INT_LIM)
  ) u_filter (
    .clk         (clk),
    .rst         (rst),
    .err_i       (bus.ted_err_i),
    .err_val_i   (bus.ted_val_i),
    .delta_o     (delta),
    .delta_val_o (delta_val),
    .integ_o     (integ)
  );

  // Strobe cadence is set by the counter alone; tau only moves the interpolation point.
  assign strobe = bus.iq_raw_val_i && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (bus.iq_raw_val_i) cnt_d = strobe ? '0 : cnt_q + 1'b1;
  end

  // |delta| <= one sample, so a single add or subtract of the modulus restores range.
  always_comb begin
    tau_d   = tau_q;
    slip_d  = SLIP_NONE;
    tau_sum = acc_t'({2'b00, tau_q}) + delta;
    if (delta_val) begin
      if (tau_sum >= TAU_MOD) begin
        tau_d  = tau_t'(tau_sum - TAU_MOD);
        slip_d = SLIP_OVF;
      end else if (tau_sum < 0) begin
        tau_d  = tau_t'(tau_sum + TAU_MOD);
        slip_d = SLIP_UDF;
      end else begin
        tau_d  = tau_t'(tau_sum);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      tau_q   <= TAU_INIT;
      slip_q  <= SLIP_NONE;
      i_q     <= '0;
      q_q     <= '0;
      val_q   <= 1'b0;
      sym_q   <= 1'b0;
      phase_q <= '0;
      mu_q    <= '0;
    end else begin
      cnt_q  <= cnt_d;
      tau_q  <= tau_d;
      slip_q <= slip_d;
      i_q    <= bus.i_raw_i;
      q_q    <= bus.q_raw_i;
      val_q  <= bus.iq_raw_val_i;
      sym_q  <= strobe;
      if (strobe) begin
        phase_q <= tau_q[FRAC_W +: PH_W];
        mu_q    <= tau_q[FRAC_W-1:0];
      end
    end
  end

  assign bus.i_raw_o      = i_q;
  assign bus.q_raw_o      = q_q;
  assign bus.iq_raw_val_o = val_q;
  assign bus.sym_valid_o  = sym_q;
  assign bus.phase_int_o  = phase_q;
  assign bus.mu_o         = mu_q;
  assign bus.slip_o       = slip_q;
  assign bus.integ_o      = integ;

endmodule

// File: tb/tb_timing_nco_loop.sv
// Scoreboard bench for timing_nco_loop: a default-gain instance and a
// KP=1/KI~0 instance started near the wrap point exercise slips and clamping.
module tb_timing_nco_loop;
  import msk_timing_pkg::*;

  localparam int     WIQ = 16;
  localparam int     WE  = 18;
  localparam longint MOD = 64'd2684354560;   // 20 * 2^27

  typedef struct packed { logic [15:0] i; logic [15:0] q; } data_t;
  typedef struct packed { logic [15:0] idx; logic [4:0] ph; logic [26:0] mu; } strb_t;

  logic clk = 1'b0;
  logic rst_m, rst_v;
  always #5 clk = ~clk;

  timing_nco_loop_if #(.WIQ(WIQ), .WE(WE)) bm ();
  timing_nco_loop_if #(.WIQ(WIQ), .WE(WE)) bv ();

  timing_nco_loop #(.OSF(20), .WIQ(WIQ), .WE(WE)) u_main (
    .clk (clk),
    .rst (rst_m),
    .bus (bm.slave)
  );

  timing_nco_loop #(
    .OSF(20), .WIQ(WIQ), .WE(WE), .KP_SHIFT(0), .KI_SHIFT(31),
    .TAU_INIT(32'd2650800128)   // 19.75 samples
  ) u_ovf (
    .clk (clk),
    .rst (rst_v),
    .bus (bv.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  data_t      exp_data[$];
  strb_t      exp_strb[$];
  strb_t      exp_strb_v[$];
  logic [1:0] exp_slip_v[$];
  int         slip_ovf_m = 0;
  int         slip_udf_m = 0;
  logic [15:0] idx_m = '0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_event(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: output with no expected entry at %0t", name, $time);
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin : mon_main
    data_t d;
    strb_t s;
    if (bm.sym_valid_o) check("main_sym_implies_val", bm.iq_raw_val_o, 1);
    if (bm.iq_raw_val_o) begin
      if (exp_data.size() == 0) fail_event("main_data");
      else begin
        d = exp_data.pop_front();
        check("main_i_raw_o", bm.i_raw_o, d.i);
        check("main_q_raw_o", bm.q_raw_o, d.q);
      end
    end
    if (bm.sym_valid_o) begin
      if (exp_strb.size() == 0) fail_event("main_strobe");
      else begin
        s = exp_strb.pop_front();
        check("main_strobe_sample", bm.i_raw_o, s.idx);
        check("main_phase_int_o", bm.phase_int_o, s.ph);
        check("main_mu_o", bm.mu_o, s.mu);
      end
    end
    if (bm.slip_o == 2'b01) slip_ovf_m++;
    if (bm.slip_o == 2'b10) slip_udf_m++;
  end

  always @(negedge clk) begin : mon_ovf
    strb_t s;
    if (bv.sym_valid_o) begin
      if (exp_strb_v.size() == 0) fail_event("ovf_strobe");
      else begin
        s = exp_strb_v.pop_front();
        check("ovf_phase_int_o", bv.phase_int_o, s.ph);
        check("ovf_mu_o", bv.mu_o, s.mu);
      end
    end
    if (bv.slip_o != 2'b00) begin
      if (exp_slip_v.size() == 0) fail_event("ovf_slip");
      else check("ovf_slip_o", bv.slip_o, exp_slip_v.pop_front());
    end
  end

  // ---------------- main-instance drivers ----------------
  task automatic samp_m(input bit v);
    @(posedge clk); #1;
    bm.iq_raw_val_i = v;
    bm.ted_val_i    = 1'b0;
    if (v) begin
      idx_m++;
      bm.i_raw_i = idx_m;
      bm.q_raw_i = ~idx_m;
      exp_data.push_back('{idx_m, ~idx_m});
    end else begin
      bm.i_raw_i = 16'hDEAD;
      bm.q_raw_i = 16'hBEEF;
    end
  endtask

  task automatic err_m(input int e);
    @(posedge clk); #1;
    bm.iq_raw_val_i = 1'b0;
    bm.ted_val_i    = 1'b1;
    bm.ted_err_i    = WE'(e);
  endtask

  // nsym symbols of 20 valid samples, each followed by gap idle cycles.
  task automatic run_m(input int nsym, input int gap, input logic [4:0] ph, input logic [26:0] mu);
    for (int s = 0; s < nsym; s++) begin
      for (int k = 1; k <= 20; k++) begin
        if (k == 20) exp_strb.push_back('{idx_m + 16'd1, ph, mu});
        samp_m(1'b1);
        for (int g = 0; g < gap; g++) samp_m(1'b0);
      end
    end
  endtask

  task automatic reset_m(input int n, input string tag);
    @(posedge clk); #1;
    rst_m = 1'b1;
    bm.iq_raw_val_i = 1'b0;
    bm.ted_val_i    = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst_m = 1'b0;
    check({tag, "_i_raw_o"}, bm.i_raw_o, 0);
    check({tag, "_q_raw_o"}, bm.q_raw_o, 0);
    check({tag, "_iq_raw_val_o"}, bm.iq_raw_val_o, 0);
    check({tag, "_sym_valid_o"}, bm.sym_valid_o, 0);
    check({tag, "_phase_int_o"}, bm.phase_int_o, 0);
    check({tag, "_mu_o"}, bm.mu_o, 0);
    check({tag, "_slip_o"}, bm.slip_o, 0);
    check({tag, "_integ_o"}, $signed(bm.integ_o), 0);
  endtask

  // ---------------- overflow-instance drivers ----------------
  task automatic samp_v(input bit v);
    @(posedge clk); #1;
    bv.iq_raw_val_i = v;
    bv.ted_val_i    = 1'b0;
  endtask

  task automatic err_v(input int e);
    @(posedge clk); #1;
    bv.iq_raw_val_i = 1'b0;
    bv.ted_val_i    = 1'b1;
    bv.ted_err_i    = WE'(e);
  endtask

  task automatic symbol_v(input logic [4:0] ph, input logic [26:0] mu);
    exp_strb_v.push_back('{16'd0, ph, mu});
    repeat (20) samp_v(1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    longint     m_tau;
    longint     m_integ;
    int         m_wraps;
    logic [31:0] tau_bits;

    rst_m = 1'b1;
    rst_v = 1'b1;
    bm.i_raw_i = '0; bm.q_raw_i = '0; bm.iq_raw_val_i = 1'b0; bm.ted_err_i = '0; bm.ted_val_i = 1'b0;
    bv.i_raw_i = '0; bv.q_raw_i = '0; bv.iq_raw_val_i = 1'b0; bv.ted_err_i = '0; bv.ted_val_i = 1'b0;

    reset_m(3, "rst0");

    // Free run and gapped valid: tau stays at 10.0.
    run_m(5, 0, 5'd10, 27'd0);
    run_m(2, 2, 5'd10, 27'd0);

    // Single error 0.5: integ = 2^18, delta = 2^24 + 2^18.
    err_m(65536);
    repeat (3) samp_m(1'b0);
    check("single_err_integ", $signed(bm.integ_o), 262144);
    run_m(1, 0, 5'd10, 27'd17039360);

    // Saturation: step values 131071<<10 >>>8 = 524284 and >>>2 = 33554176.
    m_tau   = 64'd1359216640;
    m_integ = 64'd262144;
    m_wraps = 0;
    for (int k = 0; k < 2000; k++) begin
      err_m(131071);
      m_integ = m_integ + 524284;
      if (m_integ > 67108864) m_integ = 67108864;
      m_tau = m_tau + 33554176 + m_integ;
      if (m_tau >= MOD) begin
        m_tau = m_tau - MOD;
        m_wraps++;
      end
    end
    repeat (3) samp_m(1'b0);
    check("sat_integ", $signed(bm.integ_o), 67108864);
    check("sat_ovf_slips", slip_ovf_m, m_wraps);
    check("sat_udf_slips", slip_udf_m, 0);
    tau_bits = m_tau[31:0];
    run_m(1, 0, tau_bits[31:27], tau_bits[26:0]);

    // Reset at cnt = 7 with an error still in flight.
    repeat (7) samp_m(1'b1);
    err_m(-65536);
    reset_m(2, "rst_mid");
    run_m(1, 0, 5'd10, 27'd0);
    repeat (3) samp_m(1'b0);

    // Overflow / underflow / clamp on the second instance.
    @(posedge clk); #1;
    rst_v = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_v = 1'b0;
    check("ovf_rst_phase", bv.phase_int_o, 0);
    check("ovf_rst_integ", $signed(bv.integ_o), 0);

    exp_slip_v.push_back(2'b01);
    err_v(65536);
    repeat (3) samp_v(1'b0);
    check("ovf_integ", $signed(bv.integ_o), 0);
    symbol_v(5'd0, 27'd33554432);

    exp_slip_v.push_back(2'b10);
    err_v(-65536);
    repeat (3) samp_v(1'b0);
    check("udf_integ", $signed(bv.integ_o), -1);
    symbol_v(5'd19, 27'd100663295);

    err_v(-131072);
    repeat (3) samp_v(1'b0);
    check("clamp_integ", $signed(bv.integ_o), -2);
    symbol_v(5'd18, 27'd100663295);

    repeat (5) samp_v(1'b0);
    check("main_data_drained", exp_data.size(), 0);
    check("main_strobes_drained", exp_strb.size(), 0);
    check("ovf_strobes_drained", exp_strb_v.size(), 0);
    check("ovf_slips_drained", exp_slip_v.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
